// File: rtl/mem_bus_if.sv
// Core-side request/response and external-memory pin bundle for mem_bus_interface.
// slave = the bus interface block, master = the core / pin environment.
interface mem_bus_if #(
  parameter int ADDR_W = 16,
  parameter int PIN_W  = 8,
  parameter int WAIT_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [PIN_W-1:0]  req_wdata;
  logic [WAIT_W-1:0] wait_states;
  logic              ext_rdy;
  logic              rsp_valid;
  logic              rsp_err;
  logic [PIN_W-1:0]  rsp_rdata;
  logic [1:0]        phase;
  logic [PIN_W-1:0]  uo_out;
  logic [PIN_W-1:0]  uio_in;
  logic [PIN_W-1:0]  uio_out;
  logic [PIN_W-1:0]  uio_oe;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, wait_states, ext_rdy, uio_in,
    output req_ready, rsp_valid, rsp_err, rsp_rdata, phase, uo_out, uio_out, uio_oe
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, wait_states, ext_rdy, uio_in,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata, phase, uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/mem_bus_interface.sv
// External-memory bus interface: one request at a time, address multiplexed MSB slice
// first over uo_out, data on uio, programmable wait states and ext_rdy stall timeout.
//
// state | meaning
// IDLE  | ready for a request, pins released
// ADDR  | address slices driven, idx counts down to 0
// DATA  | wait states, then wait for ext_rdy (or timeout)
// DONE  | one-cycle response strobe
module mem_bus_interface #(
  parameter int ADDR_W  = 16,
  parameter int PIN_W   = 8,
  parameter int WAIT_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst_n,
  mem_bus_if.slave bus
);
  localparam int NSLICE = ADDR_W / PIN_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int ST_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_ADDR = 2'b01,
    S_DATA = 2'b10,
    S_DONE = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [PIN_W-1:0]  wdata_q, wdata_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [ST_W-1:0]   stall_q, stall_d;
  logic [PIN_W-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ST_W:0]     stall_inc;
  logic [NSLICE-1:0][PIN_W-1:0] slices;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      wcnt_q      <= '0;
      stall_q     <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      stall_q     <= stall_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign stall_inc = {1'b0, stall_q} + {{ST_W{1'b0}}, 1'b1};

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    stall_d = stall_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          we_d    = bus.req_we;
          wdata_d = bus.req_wdata;
          idx_d   = IDX_W'(NSLICE - 1);
          wcnt_d  = bus.wait_states;
          stall_d = '0;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        if (idx_q == '0) state_d = S_DATA;
        else             idx_d   = idx_q - 1'b1;
      end
      S_DATA: begin
        if (wcnt_q != '0) begin
          wcnt_d = wcnt_q - 1'b1;
        end else if (bus.ext_rdy) begin
          if (!we_q) rdata_d = bus.uio_in;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          stall_d = stall_inc[ST_W-1:0];
          // abort on the edge where the stall count reaches TIMEOUT
          if (stall_inc == (ST_W+1)'(TIMEOUT)) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rsp_valid_d = (state_d == S_DONE);
  assign slices      = addr_q;

  always_comb begin
    bus.req_ready = 1'b0;
    bus.uo_out    = '0;
    bus.uio_out   = '0;
    bus.uio_oe    = '0;
    unique case (state_q)
      S_IDLE: bus.req_ready = 1'b1;
      S_ADDR: begin
        bus.uo_out  = slices[idx_q];
        bus.uio_out = {{(PIN_W-1){1'b0}}, ~we_q};
        bus.uio_oe  = '1;
      end
      S_DATA: begin
        bus.uo_out = slices[0];
        if (we_q) begin
          bus.uio_out = wdata_q;
          bus.uio_oe  = '1;
        end
      end
      default: ;
    endcase
  end

  assign bus.phase     = state_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = rdata_q;
endmodule

// File: tb/tb_mem_bus_interface.sv
// Scoreboard bench: stimulus pushes expected pin cycles and responses, per-DUT monitors
// pop and compare on the falling edge.
module tb_mem_bus_interface;
  typedef struct {
    logic [1:0] ph;
    logic [7:0] uo;
    logic [7:0] uout;
    logic [7:0] oe;
  } pin_t;
  typedef struct {
    logic [7:0] rd;
    logic       err;
    int         k;
  } rsp_t;

  logic clk;
  logic rst_n;
  logic mon_en;
  int   err_cnt;
  int   chk_cnt;

  logic        rv[3];
  logic        rwe[3];
  logic [23:0] raddr[3];
  logic [7:0]  rwd[3];
  logic [3:0]  rws[3];
  logic        rext[3];
  logic [7:0]  ruin[3];
  logic [7:0]  exp_rdata[3];
  int          k_cnt[3];
  pin_t        pinq[3][$];
  rsp_t        rspq[3][$];

  mem_bus_if #(.ADDR_W(16), .PIN_W(8), .WAIT_W(4)) bus0 ();
  mem_bus_if #(.ADDR_W(16), .PIN_W(8), .WAIT_W(4)) bus1 ();
  mem_bus_if #(.ADDR_W(24), .PIN_W(8), .WAIT_W(4)) bus2 ();

  mem_bus_interface #(.ADDR_W(16), .PIN_W(8), .WAIT_W(4), .TIMEOUT(255))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mem_bus_interface #(.ADDR_W(16), .PIN_W(8), .WAIT_W(4), .TIMEOUT(4))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mem_bus_interface #(.ADDR_W(24), .PIN_W(8), .WAIT_W(4), .TIMEOUT(255))
    dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  assign bus0.req_valid = rv[0];   assign bus1.req_valid = rv[1];   assign bus2.req_valid = rv[2];
  assign bus0.req_we = rwe[0];     assign bus1.req_we = rwe[1];     assign bus2.req_we = rwe[2];
  assign bus0.req_addr = raddr[0][15:0];
  assign bus1.req_addr = raddr[1][15:0];
  assign bus2.req_addr = raddr[2];
  assign bus0.req_wdata = rwd[0];  assign bus1.req_wdata = rwd[1];  assign bus2.req_wdata = rwd[2];
  assign bus0.wait_states = rws[0]; assign bus1.wait_states = rws[1]; assign bus2.wait_states = rws[2];
  assign bus0.ext_rdy = rext[0];   assign bus1.ext_rdy = rext[1];   assign bus2.ext_rdy = rext[2];
  assign bus0.uio_in = ruin[0];    assign bus1.uio_in = ruin[1];    assign bus2.uio_in = ruin[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] expv);
    chk_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", nm, d, act, expv, $time);
    end
  endtask

  task automatic mon(input int d, input logic [1:0] ph, input logic [7:0] uo, input logic [7:0] uout,
                     input logic [7:0] oe, input logic rsv, input logic rerr, input logic [7:0] rd,
                     input logic rdy, input logic rqv);
    pin_t p;
    rsp_t r;
    k_cnt[d]++;
    chk("req_ready", d, rdy, ph == 2'b00);
    chk("rsp_valid_in_done", d, rsv, ph == 2'b11);
    if (ph != 2'b00) begin
      if (pinq[d].size() == 0) begin
        chk("pin_unexpected_phase", d, ph, 0);
      end else begin
        p = pinq[d].pop_front();
        chk("phase", d, ph, p.ph);
        chk("uo_out", d, uo, p.uo);
        if (p.ph != 2'b11) chk("uio_out", d, uout, p.uout);
        chk("uio_oe", d, oe, p.oe);
      end
    end else begin
      chk("idle_uo_out", d, uo, 0);
      chk("idle_uio_out", d, uout, 0);
      chk("idle_uio_oe", d, oe, 0);
      chk("rsp_rdata_held", d, rd, exp_rdata[d]);
    end
    if (rsv) begin
      if (rspq[d].size() == 0) begin
        chk("rsp_unexpected", d, rsv, 0);
      end else begin
        r = rspq[d].pop_front();
        chk("rsp_rdata", d, rd, r.rd);
        chk("rsp_err", d, rerr, r.err);
        chk("rsp_latency", d, k_cnt[d], r.k);
      end
    end
    if (rqv && rdy) k_cnt[d] = 0;
  endtask

  always @(negedge clk) if (mon_en)
    mon(0, bus0.phase, bus0.uo_out, bus0.uio_out, bus0.uio_oe, bus0.rsp_valid, bus0.rsp_err,
        bus0.rsp_rdata, bus0.req_ready, bus0.req_valid);
  always @(negedge clk) if (mon_en)
    mon(1, bus1.phase, bus1.uo_out, bus1.uio_out, bus1.uio_oe, bus1.rsp_valid, bus1.rsp_err,
        bus1.rsp_rdata, bus1.req_ready, bus1.req_valid);
  always @(negedge clk) if (mon_en)
    mon(2, bus2.phase, bus2.uo_out, bus2.uio_out, bus2.uio_oe, bus2.rsp_valid, bus2.rsp_err,
        bus2.rsp_rdata, bus2.req_ready, bus2.req_valid);

  // Issue one request; ext_rdy is high during ADDR and wait cycles (must be ignored),
  // low for s stall cycles (or forever on abort); uio_in carries rd only on the sample cycle.
  task automatic run_req(input int d, input int ns, input int tmo, input bit we,
                         input logic [23:0] addr, input logic [7:0] wd, input int w, input int s,
                         input bit abort, input logic [7:0] rd, input int rst_at);
    pin_t p;
    rsp_t r;
    pin_t lst[$];
    int dcyc, kdone, kend;
    rv[d] = 1'b1; rwe[d] = we; raddr[d] = addr; rwd[d] = wd; rws[d] = 4'(w);
    rext[d] = 1'b1; ruin[d] = ~rd;
    @(posedge clk); #1;
    rv[d] = 1'b0; rwe[d] = ~we; raddr[d] = ~addr; rwd[d] = ~wd; rws[d] = ~4'(w);
    dcyc  = abort ? (w + tmo) : (w + s + 1);
    kdone = ns + dcyc + 1;
    kend  = (rst_at != 0) ? rst_at : kdone;
    for (int k = 1; k <= ns; k++) begin
      p.ph = 2'b01; p.uo = 8'(addr >> ((ns - k) * 8)); p.uout = {7'b0, ~we}; p.oe = 8'hFF;
      lst.push_back(p);
    end
    for (int k = 0; k < dcyc; k++) begin
      p.ph = 2'b10; p.uo = addr[7:0]; p.uout = we ? wd : 8'h00; p.oe = we ? 8'hFF : 8'h00;
      lst.push_back(p);
    end
    p.ph = 2'b11; p.uo = 8'h00; p.uout = 8'h00; p.oe = 8'h00;
    lst.push_back(p);
    for (int i = 0; i < kend; i++) pinq[d].push_back(lst[i]);
    if (rst_at == 0) begin
      r.rd  = we ? exp_rdata[d] : (abort ? 8'h00 : rd);
      r.err = abort;
      r.k   = kdone;
      rspq[d].push_back(r);
    end
    for (int k = 1; k <= kend; k++) begin
      ruin[d] = ~rd;
      if (k <= ns + w) rext[d] = 1'b1;
      else if (abort) rext[d] = 1'b0;
      else if (k <= ns + w + s) rext[d] = 1'b0;
      else if (k == ns + w + s + 1) begin rext[d] = 1'b1; ruin[d] = rd; end
      else rext[d] = 1'b1;
      if (k == rst_at) rst_n = 1'b0;
      @(posedge clk); #1;
    end
    if (rst_at != 0) begin
      for (int i = 0; i < 3; i++) exp_rdata[i] = 8'h00;
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else if (!we) begin
      exp_rdata[d] = abort ? 8'h00 : rd;
    end
    rext[d] = 1'b1;
    ruin[d] = 8'h00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    err_cnt = 0; chk_cnt = 0; mon_en = 1'b0; rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = '0; rwd[i] = '0; rws[i] = '0;
      rext[i] = 1'b1; ruin[i] = '0; exp_rdata[i] = '0; k_cnt[i] = 0;
    end
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    //      d ns tmo we addr        wd     w  s  abort rd     rst_at
    run_req(0, 2, 255, 0, 24'h00BEEF, 8'h00, 0, 0, 0, 8'h5A, 0);
    run_req(0, 2, 255, 1, 24'h001234, 8'h3C, 3, 0, 0, 8'h00, 0);
    run_req(0, 2, 255, 0, 24'h000F0F, 8'h00, 2, 5, 0, 8'hC3, 0);
    run_req(1, 2, 4,   0, 24'h002468, 8'h00, 0, 0, 0, 8'h66, 0);
    run_req(1, 2, 4,   0, 24'h001111, 8'h00, 1, 0, 1, 8'hEE, 0);
    run_req(1, 2, 4,   0, 24'h002222, 8'h00, 0, 0, 0, 8'h99, 0);
    run_req(2, 3, 255, 0, 24'hABCDEF, 8'h00, 0, 0, 0, 8'h42, 0);
    run_req(2, 3, 255, 1, 24'h010203, 8'h55, 1, 0, 0, 8'h00, 0);
    run_req(0, 2, 255, 1, 24'h004321, 8'h77, 5, 0, 0, 8'h00, 4);
    run_req(0, 2, 255, 0, 24'h00A55A, 8'h00, 1, 0, 0, 8'h81, 0);

    repeat (3) begin @(posedge clk); #1; end
    for (int d = 0; d < 3; d++) begin
      chk("pin_queue_drained", d, pinq[d].size(), 0);
      chk("rsp_queue_drained", d, rspq[d].size(), 0);
    end
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/mem_bus_interface.md
# mem_bus_interface

Parametrised external-memory bus interface for the 6502 core. It accepts one read or write request at a time from the core over a valid/ready handshake and time-multiplexes the wide address over the narrow `uo_out` pins, most-significant slice first. It drives or samples data on the bidirectional `uio` pins and inserts programmable wait states. It also honours an external ready line, with an optional timeout, and returns read data with a one-cycle response strobe.

## Interface
- `ADDR_W`, default 16: address width. Must be an integer multiple of `PIN_W`.
- `PIN_W`, default 8: pin slice width; also the data width.
- `WAIT_W`, default 4: width of the wait-state count.
- `TIMEOUT`, default 255: maximum number of stall cycles on `ext_rdy`. 0 disables the timeout.
- `clk` in 1: clock.
- `rst_n` in 1: reset. Synchronous, active-low.
- `req_valid` in 1: the core presents a request.
- `req_ready` out 1: the block can accept a request.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in ADDR_W: request address.
- `req_wdata` in PIN_W: write data.
- `wait_states` in WAIT_W: extra data-phase cycles for this request.
- `ext_rdy` in 1: external device ready. 0 stretches the data phase.
- `rsp_valid` out 1: one-cycle completion strobe.
- `rsp_err` out 1: the transaction was aborted by the timeout. Qualified by `rsp_valid`.
- `rsp_rdata` out PIN_W: read data. Held until the next completion.
- `phase` out 2: bus phase. 00 = IDLE, 01 = ADDR, 10 = DATA, 11 = DONE.
- `uo_out` out PIN_W: address pins.
- `uio_in` in PIN_W: data input pins.
- `uio_out` out PIN_W: data/control output pins.
- `uio_oe` out PIN_W: output enables, 1 = drive.

## Operation
- NSLICE = ADDR_W/PIN_W. The FSM has four states: IDLE, ADDR, DATA, DONE. All outputs are decoded from registered state (Moore), except `rsp_rdata`, `rsp_err` and `rsp_valid`, which are registers.
- **IDLE**
  - Outputs: `req_ready`=1, `uo_out`=0, `uio_out`=0, `uio_oe`=0.
  - On `req_valid`=1 at a clock edge, the block latches `req_addr`, `req_we`, `req_wdata` and `wait_states`. It sets the slice index to NSLICE-1, loads the wait counter from `wait_states`, clears the stall counter and goes to ADDR.
- **ADDR**
  - Outputs: `uo_out` = latched address bits [idx*PIN_W +: PIN_W]; `uio_out` = {zeros, ~we} (bit 0 is rw, 1 = read); `uio_oe` = all ones.
  - idx decrements each cycle. After idx=0 the FSM goes to DATA.
- **DATA**
  - `uo_out` holds slice 0.
  - Write: `uio_out` = wdata, `uio_oe` = all ones.
  - Read: `uio_out` = 0, `uio_oe` = 0.
  - While the wait counter ≠ 0, it decrements and the FSM stays. `ext_rdy` is ignored during these cycles.
  - When the wait counter = 0 and `ext_rdy`=1, the phase completes. A read captures `uio_in` into `rsp_rdata`. `rsp_err` is set to 0 and the FSM goes to DONE.
  - When the wait counter = 0 and `ext_rdy`=0, the stall counter increments. If TIMEOUT≠0 and the stall counter reaches TIMEOUT, the transaction aborts: `rsp_err`=1, `rsp_rdata`=0, go to DONE.
- **DONE**
  - Outputs: `rsp_valid`=1 for exactly this cycle; `uio_oe`=0; `uo_out`=0.
  - The FSM always returns to IDLE.
- Only one transaction is in flight. `req_ready` is 1 only in IDLE.
- Changes to any `req_*` input or to `wait_states` after acceptance have no effect on the current transaction.
- A write never updates `rsp_rdata`.

## Timing
- Reset values: state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `phase`=00, `uo_out`=0, `uio_out`=0, `uio_oe`=0, all counters 0.
- Reset mid-transaction: at the next edge the block returns to IDLE with reset values. The in-flight request is dropped and no `rsp_valid` is produced.
- Latency: the acceptance edge is E. ADDR occupies cycles E+1 … E+NSLICE. DATA occupies cycles E+NSLICE+1 … E+NSLICE+1+W+S, where W is the latched wait count and S is the number of stall cycles. DONE falls in the following cycle.
- Default parameters, W=0, S=0: `rsp_valid` is high in cycle E+4, and the next request can be accepted at edge E+5.
- The read sample point is the final DATA-cycle edge. `uio_in` must be stable across that edge.
- Timeout: the abort is taken on the edge where the stall count reaches TIMEOUT. DONE follows in the next cycle.

## Test plan
- Read of 0xBEEF, W=0, `ext_rdy`=1, `uio_in`=0x5A in DATA → `uo_out` = 0xBE then 0xEF with `uio_out`=0x01 and `uio_oe`=0xFF; in DATA `uio_oe`=0x00; `rsp_valid` in cycle E+4 with `rsp_rdata`=0x5A and `rsp_err`=0.
- Write of 0x3C to 0x1234, W=3 → `uio_out`=0x00 in ADDR; DATA lasts 4 cycles with `uio_out`=0x3C and `uio_oe`=0xFF; `rsp_valid` in cycle E+7; `rsp_rdata` unchanged.
- Read with `ext_rdy` low for 5 cycles after the waits expire, TIMEOUT=255 → DATA stretched by 5 cycles; data sampled on the edge where `ext_rdy` rises; `rsp_err`=0.
- `ext_rdy` held at 0 with TIMEOUT=4 → `rsp_valid` with `rsp_err`=1 and `rsp_rdata`=0; FSM back in IDLE; a following normal read completes correctly.
- `rst_n` pulsed low during DATA of a write → outputs return to reset values on the next edge; no `rsp_valid`; `req_ready`=1.
- ADDR_W=24, read of 0xABCDEF → `uo_out` = 0xAB, 0xCD, 0xEF on three consecutive cycles; `rsp_valid` in cycle E+5.
